// File: rtl/div.sv
// Multi-cycle 32-bit restoring radix-2 divider (DIV/DIVU/REM/REMU), result = {remainder, quotient}.
// Optional macro DIV_ANNUL_EN: annul_i aborts the current division with priority over start_i.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic        signed_q, neg1_q, neg2_q;
    logic [31:0] raw_q, divisor_q, rem_q, quo_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [31:0] mag1_d, mag2_d, rem_d, quo_d, q_fix_d, r_fix_d;
    logic [32:0] trial_d;
    logic        annul_act;

`ifdef DIV_ANNUL_EN
    assign annul_act = annul_i;
`else
    logic unused_annul;
    assign annul_act    = 1'b0;
    assign unused_annul = annul_i;
`endif

    always_comb begin
        mag1_d  = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
        mag2_d  = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
        // quo_q doubles as the dividend shifter: its MSB feeds the remainder, quotient bits enter at the LSB
        trial_d = {rem_q, quo_q[31]} - {1'b0, divisor_q};
        rem_d   = trial_d[32] ? {rem_q[30:0], quo_q[31]} : trial_d[31:0];
        quo_d   = {quo_q[30:0], ~trial_d[32]};
        q_fix_d = (signed_q && (neg1_q ^ neg2_q)) ? -quo_q : quo_q;
        r_fix_d = (signed_q && neg1_q) ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            signed_q  <= 1'b0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            raw_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else if (annul_act) begin
            state_q  <= S_FREE;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FREE: begin
                    if (start_i) begin
                        signed_q  <= signed_div_i;
                        neg1_q    <= signed_div_i & opdata1_i[31];
                        neg2_q    <= signed_div_i & opdata2_i[31];
                        raw_q     <= opdata1_i;
                        divisor_q <= mag2_d;
                        rem_q     <= '0;
                        quo_q     <= mag1_d;
                        cnt_q     <= '0;
                        state_q   <= (opdata2_i == '0) ? S_BYZERO : S_ON;
                    end
                end
                S_BYZERO: begin
                    if (!start_i) begin
                        state_q  <= S_FREE;
                        result_q <= '0;
                        ready_q  <= 1'b0;
                    end else begin
                        state_q  <= S_END;
                        result_q <= {raw_q, 32'hFFFF_FFFF};
                        ready_q  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (!start_i) begin
                        state_q  <= S_FREE;
                        result_q <= '0;
                        ready_q  <= 1'b0;
                    end else if (cnt_q != 6'd32) begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 6'd1;
                    end else begin
                        state_q  <= S_END;
                        result_q <= {r_fix_d, q_fix_d};
                        ready_q  <= 1'b1;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        state_q  <= S_FREE;
                        result_q <= '0;
                        ready_q  <= 1'b0;
                    end
                end
                default: state_q <= S_FREE;
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: cycle-level reference model plus directed vectors with literal results.
// Honors DIV_ANNUL_EN the same way as the design.
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

`ifdef DIV_ANNUL_EN
    localparam bit ANNUL_ON = 1'b1;
`else
    localparam bit ANNUL_ON = 1'b0;
`endif

    // Architectural result: RISC-V M-extension semantics from plain arithmetic
    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        int sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    bit          m_busy = 1'b0;
    bit          m_ready = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res = '0;
    logic [63:0] m_pend = '0;

    // Timing model: a request is answered after a fixed edge count, or dropped when released/flushed
    always @(posedge clk) begin
        if (rst || (ANNUL_ON && annul_i)) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_res   = '0;
        end else if (m_ready) begin
            if (!start_i) begin
                m_ready = 1'b0;
                m_res   = '0;
            end
        end else if (m_busy) begin
            if (!start_i) m_busy = 1'b0;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy  = 1'b0;
                    m_ready = 1'b1;
                    m_res   = m_pend;
                end
            end
        end else if (start_i) begin
            m_busy = 1'b1;
            m_left = (opdata2_i == 0) ? 1 : 33;
            m_pend = model_div(opdata1_i, opdata2_i, signed_div_i);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (ready_o !== m_ready || result_o !== m_res) begin
                fails++;
                $display("FAIL model t=%0t ready=%b result=%h required ready=%b result=%h",
                         $time, ready_o, result_o, m_ready, m_res);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(inout int n);
        while (!ready_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release_check(input string name);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_rel"}, {ready_o, result_o}, 65'h0);
        #1;
    endtask

    // Issue one request; operands are scrambled after the accepting edge to prove they were latched
    task automatic run(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                       input logic [63:0] exp, input int exp_lat, input string name);
        int n = 0;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        n = 1;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
        wait_ready(n);
        check({name, "_lat"}, 64'(n), 64'(exp_lat));
        check({name, "_res"}, result_o, exp);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_hold"}, {63'h0, ready_o}, 64'h1);
        release_check(name);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        rst = 1'b0;
        check("reset", {ready_o, result_o}, 65'h0);

        run(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34, "u100_7");
        run(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, "s_m7_2");
        run(32'hFFFF_FFF9, 32'd2, 1'b0, {32'h1, 32'h7FFF_FFFC}, 34, "u_m7_2");
        run(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, 34, "s7_m2");
        run(32'd5, 32'd0, 1'b1, {32'd5, 32'hFFFF_FFFF}, 2, "s5_0");
        run(32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFF_FFFF}, 2, "u5_0");
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 34, "s_ovf");
        run(32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF}, 34, "umax_1");
        run(32'd3, 32'd10, 1'b0, {32'd3, 32'd0}, 34, "u3_10");

        // Abort by releasing start mid-division
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_idle", {ready_o, result_o}, 65'h0);

        // Flush pulse sampled at E10
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
`ifdef DIV_ANNUL_EN
        start_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("annul_idle", {ready_o, result_o}, 65'h0);
        #1;
        run(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 34, "u9_3");
`else
        n = 11;
        wait_ready(n);
        check("annul_ign_lat", 64'(n), 64'd34);
        check("annul_ign_res", result_o, {32'd2, 32'd14});
        release_check("annul_ign");
`endif

        // Reset sampled at E15 while the request is still held
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid", {ready_o, result_o}, 65'h0);
        n = 0;
        wait_ready(n);
        check("rst_re_lat", 64'(n), 64'd34);
        check("rst_re_res", result_o, {32'd2, 32'd14});
        release_check("rst_re");

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
